// File: rtl/control_fsm_if.sv
// Signal bundle for the multi-cycle CPU control FSM: datapath flags in, control strobes/selects and status out.
interface control_fsm_if;
    logic [3:0] opcode;
    logic       zero;
    logic       negative;
    logic       mem_ready;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       iord;
    logic [3:0] state;
    logic       halted;
    logic       error;

    modport master (
        output opcode, zero, negative, mem_ready,
        input  alu_src_a, alu_src_b, alu_op, pc_src, pc_write, ir_write, mem_read,
               mem_write, reg_write, mem_to_reg, iord, state, halted, error
    );

    modport slave (
        input  opcode, zero, negative, mem_ready,
        output alu_src_a, alu_src_b, alu_op, pc_src, pc_write, ir_write, mem_read,
               mem_write, reg_write, mem_to_reg, iord, state, halted, error
    );
endinterface

// File: rtl/control_fsm.sv
// Moore control FSM for a multi-cycle CPU datapath. Define CONTROL_MEM_WAIT_EN to make
// FETCH/MEM_READ/MEM_WRITE wait on input_mem_ready with a WAIT_LIMIT timeout into ERROR.
module control_fsm #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] input_opcode,
    input  logic       input_Zero,
    input  logic       input_negative,
    input  logic       input_mem_ready,
    output logic [1:0] output_ALUSrcA,
    output logic [1:0] output_ALUSrcB,
    output logic [2:0] output_ALUOp,
    output logic       output_PCSrc,
    output logic       output_PCWrite,
    output logic       output_IRWrite,
    output logic       output_MemRead,
    output logic       output_MemWrite,
    output logic       output_RegWrite,
    output logic       output_MemToReg,
    output logic       output_IorD,
    output logic [3:0] output_state,
    output logic       output_halted,
    output logic       output_error
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        ALU_WB    = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        HALT      = 4'd14,
        ERROR     = 4'd15
    } state_e;

    typedef struct packed {
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic       pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       iord;
        logic       halted;
        logic       error;
    } ctrl_t;

    // Static per-state decode; flag/ready-dependent strobes are ORed in after the register.
    function automatic ctrl_t decode(input state_e s, input logic [1:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read = 1'b1;
                c.src_b    = 2'd1;
`ifndef CONTROL_MEM_WAIT_EN
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
`endif
            end
            DECODE:   c.src_b = 2'd2;
            EXEC_R: begin
                c.src_a  = 2'd2;
                c.alu_op = {1'b0, op};
            end
            EXEC_I, MEM_ADDR: begin
                c.src_a = 2'd2;
                c.src_b = 2'd2;
            end
            ALU_WB:   c.reg_write = 1'b1;
            MEM_READ: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            BRANCH: begin
                c.src_a  = 2'd2;
                c.alu_op = 3'd1;
                c.pc_src = 1'b1;
            end
            HALT:     c.halted = 1'b1;
            ERROR:    c.error  = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] opc_q, opc_d;
    ctrl_t      ctrl_q;
    logic       br_taken;
    logic       fetch_done;

`ifdef CONTROL_MEM_WAIT_EN
    localparam int CW = $clog2(WAIT_LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_wait;
    logic          timeout;

    assign mem_wait   = ((state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE))
                        && !input_mem_ready;
    assign timeout    = (cnt_q == CW'(WAIT_LIMIT - 1));
    assign fetch_done = (state_q == FETCH) && input_mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = input_mem_ready;
    assign fetch_done       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                opc_d = input_opcode;
                case (input_opcode)
                    4'd0, 4'd1, 4'd2, 4'd3: state_d = EXEC_R;
                    4'd4:                   state_d = EXEC_I;
                    4'd5, 4'd6:             state_d = MEM_ADDR;
                    4'd7, 4'd8, 4'd9:       state_d = BRANCH;
                    4'd15:                  state_d = HALT;
                    default:                state_d = ERROR;
                endcase
            end
            EXEC_R, EXEC_I: state_d = ALU_WB;
            ALU_WB:         state_d = FETCH;
            MEM_ADDR:       state_d = (opc_q == 4'd5) ? MEM_READ : MEM_WRITE;
            MEM_READ:       state_d = MEM_WB;
            MEM_WB:         state_d = FETCH;
            MEM_WRITE:      state_d = FETCH;
            BRANCH:         state_d = FETCH;
            HALT:           state_d = HALT;
            ERROR:          state_d = ERROR;
            default:        state_d = ERROR;
        endcase
`ifdef CONTROL_MEM_WAIT_EN
        // Counter only runs while stalled, so any state change leaves it at zero.
        cnt_d = '0;
        if (mem_wait) begin
            state_d = timeout ? ERROR : state_q;
            cnt_d   = cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= FETCH;
            opc_q   <= '0;
            ctrl_q  <= decode(FETCH, 2'd0);
`ifdef CONTROL_MEM_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            ctrl_q  <= decode(state_d, opc_d[1:0]);
`ifdef CONTROL_MEM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign br_taken = (state_q == BRANCH) &&
                      (((opc_q == 4'd7) &&  input_Zero) ||
                       ((opc_q == 4'd8) && !input_Zero) ||
                       ((opc_q == 4'd9) &&  input_negative));

    assign output_ALUSrcA  = ctrl_q.src_a;
    assign output_ALUSrcB  = ctrl_q.src_b;
    assign output_ALUOp    = ctrl_q.alu_op;
    assign output_PCSrc    = ctrl_q.pc_src;
    assign output_PCWrite  = ctrl_q.pc_write | br_taken | fetch_done;
    assign output_IRWrite  = ctrl_q.ir_write | fetch_done;
    assign output_MemRead  = ctrl_q.mem_read;
    assign output_MemWrite = ctrl_q.mem_write;
    assign output_RegWrite = ctrl_q.reg_write;
    assign output_MemToReg = ctrl_q.mem_to_reg;
    assign output_IorD     = ctrl_q.iord;
    assign output_state    = state_q;
    assign output_halted   = ctrl_q.halted;
    assign output_error    = ctrl_q.error;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed vector table, multi-cycle corner sequences, randomized instruction stream vs model.
module tb_control_fsm;
    localparam int WL = 15;
`ifdef CONTROL_MEM_WAIT_EN
    localparam bit WAITM = 1'b1;
`else
    localparam bit WAITM = 1'b0;
`endif

    logic CLK = 1'b0;
    logic Reset;
    control_fsm_if bus();

    control_fsm #(.WAIT_LIMIT(WL)) dut (
        .CLK(CLK), .Reset(Reset),
        .input_opcode(bus.opcode), .input_Zero(bus.zero), .input_negative(bus.negative),
        .input_mem_ready(bus.mem_ready),
        .output_ALUSrcA(bus.alu_src_a), .output_ALUSrcB(bus.alu_src_b), .output_ALUOp(bus.alu_op),
        .output_PCSrc(bus.pc_src), .output_PCWrite(bus.pc_write), .output_IRWrite(bus.ir_write),
        .output_MemRead(bus.mem_read), .output_MemWrite(bus.mem_write), .output_RegWrite(bus.reg_write),
        .output_MemToReg(bus.mem_to_reg), .output_IorD(bus.iord), .output_state(bus.state),
        .output_halted(bus.halted), .output_error(bus.error)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    wire [20:0] act = {bus.state, bus.halted, bus.error, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                       bus.pc_src, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                       bus.reg_write, bus.mem_to_reg, bus.iord};

    typedef struct {
        logic [3:0]  opc;
        logic        z;
        logic        n;
        logic [20:0] exp;
    } vec_t;
    vec_t tv[$];

    // strobes sb = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemToReg, IorD}
    function automatic logic [20:0] pk(input logic [3:0] st, input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] op, input logic pcs, input logic [6:0] sb,
                                       input logic h, input logic e);
        return {st, h, e, a, b, op, pcs, sb};
    endfunction

    function automatic logic [20:0] eF();  return pk(4'd0, 2'd0, 2'd1, 3'd0, 1'b0, 7'b1110000, 1'b0, 1'b0); endfunction
    function automatic logic [20:0] eD();  return pk(4'd1, 2'd0, 2'd2, 3'd0, 1'b0, 7'b0000000, 1'b0, 1'b0); endfunction
    function automatic logic [20:0] eR(input logic [2:0] op);
        return pk(4'd2, 2'd2, 2'd0, op, 1'b0, 7'b0000000, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] eI();  return pk(4'd3, 2'd2, 2'd2, 3'd0, 1'b0, 7'b0000000, 1'b0, 1'b0); endfunction
    function automatic logic [20:0] eW();  return pk(4'd4, 2'd0, 2'd0, 3'd0, 1'b0, 7'b0000100, 1'b0, 1'b0); endfunction
    function automatic logic [20:0] eMA(); return pk(4'd5, 2'd2, 2'd2, 3'd0, 1'b0, 7'b0000000, 1'b0, 1'b0); endfunction
    function automatic logic [20:0] eMR(); return pk(4'd6, 2'd0, 2'd0, 3'd0, 1'b0, 7'b0010001, 1'b0, 1'b0); endfunction
    function automatic logic [20:0] eMB(); return pk(4'd7, 2'd0, 2'd0, 3'd0, 1'b0, 7'b0000110, 1'b0, 1'b0); endfunction
    function automatic logic [20:0] eMW(); return pk(4'd8, 2'd0, 2'd0, 3'd0, 1'b0, 7'b0001001, 1'b0, 1'b0); endfunction
    function automatic logic [20:0] eB(input logic t);
        return pk(4'd9, 2'd2, 2'd0, 3'd1, 1'b1, {t, 6'b000000}, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] eH();  return pk(4'd14, 2'd0, 2'd0, 3'd0, 1'b0, 7'b0000000, 1'b1, 1'b0); endfunction
    function automatic logic [20:0] eE();  return pk(4'd15, 2'd0, 2'd0, 3'd0, 1'b0, 7'b0000000, 1'b0, 1'b1); endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic [3:0] o, input logic z, input logic n, input logic r);
        bus.opcode    = o;
        bus.zero      = z;
        bus.negative  = n;
        bus.mem_ready = r;
        #1;
    endtask

    task automatic add(input logic [3:0] o, input logic z, input logic n, input logic [20:0] e);
        vec_t v;
        v.opc = o; v.z = z; v.n = n; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("reset_fetch", act, eF());
        Reset = 1'b0;
    endtask

    task automatic step(input string nm, input logic [3:0] o, input logic z, input logic r, input logic [20:0] e);
        drive(o, z, 1'b0, r);
        chk(nm, act, e);
        tick();
    endtask

    // Random instruction stream checked against a per-instruction state-list model.
    task automatic run_random(input int n_instr);
        int lowrun = 0;
        for (int k = 0; k < n_instr; k++) begin
            int op = $urandom_range(9);
            int q[$];
            if (op <= 3)      q = '{0, 1, 2, 4};
            else if (op == 4) q = '{0, 1, 3, 4};
            else if (op == 5) q = '{0, 1, 5, 6, 7};
            else if (op == 6) q = '{0, 1, 5, 8};
            else              q = '{0, 1, 9};
            foreach (q[i]) begin
                int  s = q[i];
                bit  stay;
                do begin
                    logic r, z, n, pcw, taken;
                    logic [3:0] o;
                    r = 1'b1;
                    if (WAITM && lowrun < 4 && $urandom_range(3) == 0) r = 1'b0;
                    lowrun = r ? 0 : lowrun + 1;
                    z = 1'($urandom_range(1));
                    n = 1'($urandom_range(1));
                    o = (s == 1) ? 4'(op) : 4'($urandom_range(15));
                    drive(o, z, n, r);
                    taken = (op == 7 && z) || (op == 8 && !z) || (op == 9 && n);
                    pcw = (s == 0) ? (WAITM ? r : 1'b1) : (s == 9) ? taken : 1'b0;
                    chk($sformatf("rand%0d_s%0d", k, s),
                        {bus.state, bus.reg_write, bus.mem_write, bus.mem_read, bus.pc_write},
                        {4'(s), (s == 4 || s == 7), (s == 8), (s == 0 || s == 6), pcw});
                    if (s == 2) chk($sformatf("rand%0d_aluop", k), bus.alu_op, op % 4);
                    stay = WAITM && (s == 0 || s == 6 || s == 8) && !r;
                    tick();
                end while (stay);
            end
        end
    endtask

    initial begin
        // ADD, SUB (opcode changes after DECODE), OR, ADDI
        add(4'd0, 0, 0, eF()); add(4'd0, 0, 0, eD()); add(4'd0, 0, 0, eR(3'd0)); add(4'd0, 0, 0, eW());
        add(4'd0, 0, 0, eF()); add(4'd1, 0, 0, eD()); add(4'd13, 0, 0, eR(3'd1)); add(4'd13, 0, 0, eW());
        add(4'd0, 0, 0, eF()); add(4'd3, 0, 0, eD()); add(4'd3, 0, 0, eR(3'd3)); add(4'd3, 0, 0, eW());
        add(4'd0, 0, 0, eF()); add(4'd4, 0, 0, eD()); add(4'd4, 0, 0, eI());     add(4'd4, 0, 0, eW());
        // LW with opcode flipped to SW during MEM_ADDR, then SW
        add(4'd0, 0, 0, eF()); add(4'd5, 0, 0, eD()); add(4'd6, 0, 0, eMA()); add(4'd6, 0, 0, eMR()); add(4'd0, 0, 0, eMB());
        add(4'd0, 0, 0, eF()); add(4'd6, 0, 0, eD()); add(4'd5, 0, 0, eMA()); add(4'd5, 0, 0, eMW());
        // Branches, taken and not taken
        add(4'd0, 0, 0, eF()); add(4'd7, 0, 0, eD()); add(4'd8, 1, 0, eB(1'b1));
        add(4'd0, 0, 0, eF()); add(4'd7, 0, 0, eD()); add(4'd7, 0, 0, eB(1'b0));
        add(4'd0, 0, 0, eF()); add(4'd8, 0, 0, eD()); add(4'd8, 0, 0, eB(1'b1));
        add(4'd0, 0, 0, eF()); add(4'd8, 0, 0, eD()); add(4'd8, 1, 0, eB(1'b0));
        add(4'd0, 0, 0, eF()); add(4'd9, 0, 0, eD()); add(4'd9, 0, 1, eB(1'b1));
        add(4'd0, 0, 0, eF()); add(4'd9, 0, 0, eD()); add(4'd9, 1, 0, eB(1'b0));
        add(4'd0, 0, 0, eF());

        @(negedge CLK);
        do_reset();
        foreach (tv[i]) begin
            drive(tv[i].opc, tv[i].z, tv[i].n, 1'b1);
            chk($sformatf("vec%0d", i), act, tv[i].exp);
            tick();
        end

        // Undefined opcode -> sticky ERROR, then reset clears it
        do_reset();
        step("err_f", 4'd0, 0, 1, eF());
        step("err_d", 4'd12, 0, 1, eD());
        for (int i = 0; i < 10; i++) step($sformatf("err_hold%0d", i), 4'($urandom_range(15)), 0, 1, eE());
        do_reset();

        // HALT is sticky until reset
        step("halt_f", 4'd0, 0, 1, eF());
        step("halt_d", 4'd15, 0, 1, eD());
        for (int i = 0; i < 4; i++) step($sformatf("halt_hold%0d", i), 4'd0, 0, 1, eH());
        do_reset();

        // Reset mid MEM_READ must not let MEM_WB happen
        step("rmr_f", 4'd0, 0, 1, eF());
        step("rmr_d", 4'd5, 0, 1, eD());
        step("rmr_ma", 4'd5, 0, 1, eMA());
        drive(4'd5, 0, 0, 1);
        chk("rmr_mr", act, eMR());
        do_reset();
        step("rmr_after", 4'd0, 0, 1, eF());
        step("rmr_dec", 4'd4, 0, 1, eD());
        step("rmr_exi", 4'd0, 0, 1, eI());
        step("rmr_wb", 4'd0, 0, 1, eW());

`ifdef CONTROL_MEM_WAIT_EN
        // FETCH stall: MemRead held, PC/IR writes only on the ready cycle
        do_reset();
        step("fw_stall", 4'd0, 0, 0, pk(4'd0, 2'd0, 2'd1, 3'd0, 1'b0, 7'b0010000, 1'b0, 1'b0));
        step("fw_go", 4'd0, 0, 1, eF());
        step("fw_d", 4'd6, 0, 1, eD());
        step("fw_ma", 4'd6, 0, 1, eMA());
        for (int i = 0; i < 3; i++) step($sformatf("sw_wait%0d", i), 4'd0, 0, 0, eMW());
        step("sw_ready", 4'd0, 0, 1, eMW());
        step("sw_back", 4'd0, 0, 1, eF());
        // No ready: exactly WL cycles in MEM_WRITE, then ERROR
        step("to_d", 4'd6, 0, 1, eD());
        step("to_ma", 4'd6, 0, 1, eMA());
        for (int i = 0; i < WL; i++) step($sformatf("to_wait%0d", i), 4'd0, 0, 0, eMW());
        step("to_err", 4'd0, 0, 0, eE());
`endif

        do_reset();
        run_random(250);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, max CLK cycles in a memory-wait state before error (with CONTROL_MEM_WAIT_EN).
REQ-002 SHALL have ports, in this order:
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- input_opcode  input  4  IR[15:12]
- input_Zero  input  1  ALU zero flag
- input_negative  input  1  ALU negative flag
- input_mem_ready  input  1  memory done strobe
- output_ALUSrcA  output  2  0=PC, 1=const 2, 2=A reg
- output_ALUSrcB  output  2  0=B reg, 1=const 2, 2=imm
- output_ALUOp  output  3  0=ADD, 1=SUB, 2=AND, 3=OR
- output_PCSrc  output  1  0=ALU result, 1=ALUOut
- output_PCWrite, output_IRWrite, output_MemRead, output_MemWrite, output_RegWrite, output_MemToReg, output_IorD  output  1 each  datapath strobes/selects
- output_state  output  4  current state code
- output_halted, output_error  output  1 each  sticky status

Function
REQ-003 SHALL be a Moore FSM; all outputs decode from the state register only; unlisted strobes 0, selects 0.
REQ-004 States/codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_READ=6, MEM_WB=7, MEM_WRITE=8, BRANCH=9, HALT=14, ERROR=15.
REQ-005 FETCH: IorD=0, MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSrc=0, PCWrite=1; -> DECODE.
REQ-006 DECODE: ALUSrcA=0, ALUSrcB=2, ALUOp=ADD (branch target into ALUOut); dispatch on input_opcode: 0-3 -> EXEC_R, 4 -> EXEC_I, 5/6 -> MEM_ADDR, 7-9 -> BRANCH, 15 -> HALT, 10-14 -> ERROR.
REQ-007 EXEC_R: ALUSrcA=2, ALUSrcB=0, ALUOp=opcode[1:0]; -> ALU_WB.
REQ-008 EXEC_I: ALUSrcA=2, ALUSrcB=2, ALUOp=ADD; -> ALU_WB.
REQ-009 ALU_WB: RegWrite=1, MemToReg=0; -> FETCH.
REQ-010 MEM_ADDR: ALUSrcA=2, ALUSrcB=2, ALUOp=ADD; opcode 5 -> MEM_READ, 6 -> MEM_WRITE.
REQ-011 MEM_READ: IorD=1, MemRead=1; exit -> MEM_WB. MEM_WB: RegWrite=1, MemToReg=1; -> FETCH.
REQ-012 MEM_WRITE: IorD=1, MemWrite=1; exit -> FETCH.
REQ-013 BRANCH: ALUSrcA=2, ALUSrcB=0, ALUOp=SUB, PCSrc=1; PCWrite=1 only if taken: opcode 7 (BEQ) Zero=1, 8 (BNE) Zero=0, 9 (BLT) negative=1; -> FETCH. Sole exception to REQ-003: PCWrite depends combinationally on flags.
REQ-014 Opcode latched into internal register in DECODE; later states use latched value, not input_opcode.
REQ-015 HALT and ERROR SHALL self-loop, all strobes 0; output_halted=1 in HALT, output_error=1 in ERROR; exit only via Reset.
REQ-016 Instruction latency (no waits): R/I 4, LW 5, SW 4, branch 3 cycles.

Reset
REQ-017 Reset=1 at CLK edge SHALL force FETCH, clear latched opcode and wait counter, regardless of current state (incl. mid memory access, HALT, ERROR).
REQ-018 During/after reset, outputs SHALL be FETCH decode; output_state=0, output_halted=0, output_error=0.

Configuration
REQ-019 Macro CONTROL_MEM_WAIT_EN defined: FETCH, MEM_READ, MEM_WRITE hold (strobes held steady, PCWrite/IRWrite asserted only on the ready cycle) until input_mem_ready=1, then advance; counter clears on state entry; if WAIT_LIMIT cycles elapse without ready -> ERROR.
REQ-020 Macro undefined: those states last exactly one cycle; input_mem_ready ignored; no counter logic.

Verification
REQ-021 Reset, opcode=0 (ADD): states 0,1,2,4,0; RegWrite=1 only in cycle 4; ALUOp=0 in EXEC_R.
REQ-022 opcode=7, Zero=1: 0,1,9,0 with PCWrite=1, PCSrc=1 in BRANCH; repeat Zero=0: PCWrite=0 in BRANCH.
REQ-023 opcode=5 (LW): 0,1,5,6,7,0; MemRead=1/IorD=1 in MEM_READ, MemToReg=1/RegWrite=1 in MEM_WB.
REQ-024 opcode=12 -> state 15, output_error=1 held 10 cycles; opcode=15 -> state 14, halted=1; Reset -> state 0, flags 0.
REQ-025 CONTROL_MEM_WAIT_EN, opcode=6, mem_ready low 3 cycles then high in MEM_WRITE: MemWrite=1 for 4 cycles then FETCH; ready never high, WAIT_LIMIT=15 -> ERROR after 15 cycles.
REQ-026 Reset asserted in MEM_READ: next state FETCH, no RegWrite pulse.
